// File: rtl/lzd_seq_ctrl.sv
// Sequenced leading-zero counter and normalizer.
// One 4-bit LZD slice is reused, scanning a nibble per cycle from the MSB.
module lzd_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             din,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   lz_count,
  output logic                         zero,
  output logic [WIDTH-1:0]             norm_out
);

  localparam int NNIB = WIDTH / 4;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int IW   = $clog2(NNIB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_work;
  logic [CW-1:0]     r_acc;
  logic [IW-1:0]     r_idx;
  logic              r_busy;
  logic              r_done;
  logic [CW-1:0]     r_lz;
  logic              r_zero;
  logic [WIDTH-1:0]  r_norm;

  logic [3:0]        w_nib;
  logic              w_nz;
  logic [1:0]        w_lzd;
  logic              w_last;
  logic              w_cap;

  // shared 4-bit LZD slice on the top nibble of the working word
  assign w_nib  = r_work[WIDTH-1 -: 4];
  assign w_nz   = |w_nib;
  assign w_last = (r_idx == IW'(NNIB - 1));

  always_comb begin
    w_lzd = 2'd3;
    unique casez (w_nib)
      4'b1???: w_lzd = 2'd0;
      4'b01??: w_lzd = 2'd1;
      4'b001?: w_lzd = 2'd2;
      4'b0001: w_lzd = 2'd3;
      4'b0000: w_lzd = 2'd3;
    endcase
  end

  assign w_cap = start && (r_state != SCAN);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = SCAN;
      SCAN: if (w_nz || w_last) w_next = DONE;
      DONE: w_next = start ? SCAN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == SCAN);
      r_done  <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_acc  <= '0;
      r_idx  <= '0;
      r_lz   <= '0;
      r_zero <= 1'b0;
      r_norm <= '0;
    end else if (w_cap) begin
      r_work <= din;
      r_acc  <= '0;
      r_idx  <= '0;
    end else if (r_state == SCAN) begin
      if (w_nz) begin
        r_lz   <= r_acc + CW'(w_lzd);
        r_norm <= r_work << w_lzd;
        r_zero <= 1'b0;
      end else if (!w_last) begin
        r_acc  <= r_acc + CW'(4);
        r_work <= r_work << 4;
        r_idx  <= r_idx + IW'(1);
      end else begin
        // every nibble was zero
        r_lz   <= CW'(WIDTH);
        r_zero <= 1'b1;
        r_norm <= '0;
      end
    end
  end

  assign ready    = (r_state != SCAN);
  assign busy     = r_busy;
  assign done     = r_done;
  assign lz_count = r_lz;
  assign zero     = r_zero;
  assign norm_out = r_norm;

endmodule
